stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch. It consumes the already-debounced start/stop and lap/reset button levels and runs the stopwatch mode FSM (idle, run, pause, lap-hold). It also generates the 10 ms count tick that drives the time counters, and the clear and display-freeze controls. It sits between the debounce instances and the time counter/display datapath.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_tick_div.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 96 +++++++++
 tb/tb_stopwatch_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encoding and timing constants for the stopwatch.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  localparam int unsigned c_state_w       = 2;
  localparam int unsigned c_tick_period_ms = 10;

  typedef enum logic [c_state_w-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  function automatic logic is_counting(input sw_state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_tick_div
// Description : Tick divider; one-cycle tick every TICK_DIV enabled clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_tick_div #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic hold,
  input  logic zero,
  output logic tick
);

  localparam int unsigned    c_cw   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);

  logic [c_cw-1:0] r_count;

  // zero beats hold beats enable, so a clear or IDLE entry always restarts phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      tick    <= 1'b0;
    end else if (zero) begin
      r_count <= '0;
      tick    <= 1'b0;
    end else if (hold) begin
      tick    <= 1'b0;
    end else if (enable) begin
      if (r_count == c_last) begin
        r_count <= '0;
        tick    <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
        tick    <= 1'b0;
      end
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch mode FSM, button edge/long-press detect, tick control.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHZ  = 100_000,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       tick,
  output logic       clear,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned c_tick_div = CLK_FREQ_KHZ * c_tick_period_ms;
  localparam logic [31:0] c_long     = 32'(LONG_PRESS_MS * CLK_FREQ_KHZ);

  sw_state_e   r_state;
  sw_state_e   w_next;
  logic        r_start_prev;
  logic        r_lap_prev;
  logic [31:0] r_lp_cnt;
  logic        w_start_rise;
  logic        w_lap_rise;
  logic        w_lp_hit;
  logic        w_clear;

  always_comb begin
    w_start_rise = btn_start && !r_start_prev;
    w_lap_rise   = btn_lap && !r_lap_prev && !w_start_rise;
    // fires only on the step into c_long; once saturated it stays quiet
    w_lp_hit     = btn_lap && (r_lp_cnt != c_long) && ((r_lp_cnt + 32'd1) == c_long);
    w_clear      = w_lp_hit && ((r_state == IDLE) || (r_state == PAUSE));
    w_next       = r_state;
    if (w_clear) begin
      w_next = IDLE;
    end else if (w_start_rise) begin
      case (r_state)
        IDLE:    w_next = RUN;
        RUN:     w_next = PAUSE;
        PAUSE:   w_next = RUN;
        LAP:     w_next = PAUSE;
        default: w_next = IDLE;
      endcase
    end else if (w_lap_rise) begin
      if (r_state == RUN)      w_next = LAP;
      else if (r_state == LAP) w_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_start_prev <= 1'b1;
      r_lap_prev   <= 1'b1;
      r_lp_cnt     <= '0;
      clear        <= 1'b0;
      lap_hold     <= 1'b0;
      running      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_start_prev <= btn_start;
      r_lap_prev   <= btn_lap;
      if (!btn_lap)                r_lp_cnt <= '0;
      else if (r_lp_cnt != c_long) r_lp_cnt <= r_lp_cnt + 32'd1;
      clear        <= w_clear;
      lap_hold     <= (w_next == LAP);
      running      <= is_counting(w_next);
    end
  end

  assign state = r_state;

  // divider only advances when counting both before and after the edge
  stopwatch_tick_div #(
    .TICK_DIV (c_tick_div)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (is_counting(r_state)),
    .hold   ((r_state == PAUSE) || (w_next == PAUSE)),
    .zero   (w_next == IDLE),
    .tick   (tick)
  );

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl with a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int c_tdiv = 10;
  localparam int c_lc   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start;
  logic       btn_lap;
  logic       tick;
  logic       clear;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int n_tick, n_clear, first, last;

  logic [5:0] exp_q[$];

  int m_state, m_div, m_lp;
  bit m_ps, m_pl, m_tick, m_clear;

  stopwatch_ctrl #(
    .CLK_FREQ_KHZ  (1),
    .LONG_PRESS_MS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .tick      (tick),
    .clear     (clear),
    .lap_hold  (lap_hold),
    .running   (running),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_div = 0; m_lp = 0;
    m_ps = 1'b1; m_pl = 1'b1; m_tick = 1'b0; m_clear = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit l);
    bit rs, rl, hit;
    int ns;
    rs  = s && !m_ps;
    rl  = l && !m_pl && !rs;
    hit = l && (m_lp == c_lc - 1);
    m_lp = l ? ((m_lp >= c_lc) ? c_lc : m_lp + 1) : 0;
    ns = m_state;
    m_clear = 1'b0;
    if (hit && (m_state == 0 || m_state == 2)) begin
      ns = 0;
      m_clear = 1'b1;
    end else if (rs) begin
      ns = (m_state == 0) ? 1 : (m_state == 1) ? 2 : (m_state == 2) ? 1 : 2;
    end else if (rl && m_state == 1) begin
      ns = 3;
    end else if (rl && m_state == 3) begin
      ns = 1;
    end
    m_tick = 1'b0;
    if (ns == 0) begin
      m_div = 0;
    end else if (m_state != 2 && ns != 2 && (m_state == 1 || m_state == 3)) begin
      if (m_div == c_tdiv - 1) begin
        m_div  = 0;
        m_tick = 1'b1;
      end else begin
        m_div++;
      end
    end
    m_state = ns;
    m_ps = s;
    m_pl = l;
  endtask

  // drive one cycle of buttons, queue the expected outputs, compare after the edge
  task automatic cyc(input bit s, input bit l);
    logic [5:0] e;
    btn_start = s;
    btn_lap   = l;
    model_step(s, l);
    exp_q.push_back({m_tick, m_clear, (m_state == 3), (m_state == 1 || m_state == 3), 2'(m_state)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("cycle", {26'd0, tick, clear, lap_hold, running, state}, {26'd0, e});
    if (tick)  n_tick++;
    if (clear) n_clear++;
  endtask

  initial begin
    btn_start = 1'b1;
    btn_lap   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {27'd0, tick, clear, lap_hold, running, state}, 32'd0);
    rst_n = 1'b1;

    n_tick = 0;
    repeat (30) cyc(1'b1, 1'b0);
    check_eq("held_start_state", state, 0);
    check_eq("held_start_ticks", n_tick, 0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check_eq("start_state", state, 1);
    check_eq("start_running", running, 1);

    n_tick = 0; first = 0; last = 0;
    for (int i = 1; i <= 35; i++) begin
      cyc(1'b0, 1'b0);
      if (tick) begin
        if (first == 0) first = i;
        last = i;
      end
    end
    check_eq("run_tick_count", n_tick, 3);
    check_eq("run_first_tick", first, 10);
    check_eq("run_last_tick", last, 30);

    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check_eq("pause_state", state, 2);
    n_tick = 0;
    repeat (20) cyc(1'b0, 1'b0);
    check_eq("pause_ticks", n_tick, 0);
    check_eq("pause_running", running, 0);
    cyc(1'b1, 1'b0);
    check_eq("resume_state", state, 1);
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0);
      if (tick && first == 0) first = i;
    end
    check_eq("resume_first_tick", first, 4);

    cyc(1'b0, 1'b1);
    check_eq("lap_state", state, 3);
    check_eq("lap_hold_on", lap_hold, 1);
    n_tick = 0;
    repeat (12) cyc(1'b0, 1'b0);
    check_eq("lap_ticks_continue", (n_tick > 0), 1);
    cyc(1'b0, 1'b1);
    check_eq("lap_exit_state", state, 1);
    check_eq("lap_hold_off", lap_hold, 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check_eq("lap_start_state", state, 2);
    check_eq("lap_start_hold", lap_hold, 0);
    cyc(1'b0, 1'b0);

    n_clear = 0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b1);
      if (clear && first == 0) first = i;
    end
    check_eq("lp_pause_clears", n_clear, 1);
    check_eq("lp_pause_clear_at", first, 4);
    check_eq("lp_pause_state", state, 0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0);
      if (tick && first == 0) first = i;
    end
    check_eq("post_clear_first_tick", first, 10);

    n_clear = 0;
    repeat (10) cyc(1'b0, 1'b1);
    check_eq("lp_run_clears", n_clear, 0);
    check_eq("lp_run_state", state, 3);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check_eq("back_to_run", state, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    check_eq("simul_state", state, 2);
    check_eq("simul_lap_hold", lap_hold, 0);
    cyc(1'b0, 1'b0);

    repeat (3) cyc(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", {27'd0, tick, clear, lap_hold, running, state}, 32'd0);
    model_reset();
    n_clear = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (clear) n_clear++;
    end
    check_eq("reset_no_clear", n_clear, 0);
    check_eq("reset_hold_outputs", {27'd0, tick, clear, lap_hold, running, state}, 32'd0);
    rst_n = 1'b1;
    repeat (6) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
